// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and the
// memory-mapped I/O addresses.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte addresses of the memory-mapped I/O registers.
    localparam logic [31:0] INPORT0_ADDR = 32'h0000_FFF8;
    localparam logic [31:0] INPORT1_ADDR = 32'h0000_FFFC;
    localparam logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC;

    // Width of the external switch inputs captured by the inports.
    localparam int unsigned INPORT_W = 10;

endpackage

// File: rtl/mem_ram.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
// Ports:
//   clk       - clock, rising edge
//   i_we      - write enable
//   i_addr    - word address
//   i_wdata   - write data
//   o_rdata_c - combinational read data at i_addr
module mem_ram #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write request at a time, waits
// WAIT_STATES cycles, then completes with a one-cycle ready pulse. Serves a
// word RAM plus two switch inports and one outport.
// Ports:
//   clk, rst              - clock (rising edge), async active-high reset
//   mem_rd, mem_wr        - request strobes (both high = write)
//   addr, wr_data         - byte address (addr[1:0] ignored), write data
//   rd_data, ready, busy  - read data, completion pulse, request in flight
//   switches              - external 10-bit input data
//   inport0_en/inport1_en - load switches into inport0/inport1
//   outport               - memory-mapped output register
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [WIDTH-1:0]    addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    rd_data,
    output logic                ready,
    output logic                busy,
    input  logic [INPORT_W-1:0] switches,
    input  logic                inport0_en,
    input  logic                inport1_en,
    output logic [WIDTH-1:0]    outport
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned IW = WIDTH - 2;
    localparam logic [2:0]    WAIT_LAST   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam logic [IW-1:0] IN0_WIDX    = IW'(INPORT0_ADDR >> 2);
    localparam logic [IW-1:0] IN1_WIDX    = IW'(INPORT1_ADDR >> 2);
    localparam logic [IW-1:0] OUT_WIDX    = IW'(OUTPORT_ADDR >> 2);
    localparam logic [63:0]   DEPTH_LIMIT = 64'(DEPTH_WORDS);

    state_t r_state;
    state_t w_state_next;
    logic [2:0] r_wait_cnt;
    logic [2:0] w_wait_cnt_next;
    logic       w_ready_next;
    logic       w_busy_next;
    logic       r_ready;
    logic       r_busy;

    logic [IW-1:0]       r_widx;
    logic [WIDTH-1:0]    r_wdata;
    logic                r_is_wr;
    logic [WIDTH-1:0]    r_rd_data;
    logic [WIDTH-1:0]    r_outport;
    logic [INPORT_W-1:0] r_inport0;
    logic [INPORT_W-1:0] r_inport1;

    logic             w_req;
    logic             w_in_idle;
    logic [IW-1:0]    w_acc_widx;
    logic [WIDTH-1:0] w_acc_data;
    logic             w_acc_wr;
    logic             w_fire;
    logic             w_in0_hit;
    logic             w_in1_hit;
    logic             w_out_hit;
    logic             w_ram_hit;
    logic             w_ram_we;
    logic [WIDTH-1:0] w_ram_rdata;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^addr[1:0];

    assign w_req     = mem_rd | mem_wr;
    assign w_in_idle = (r_state == IDLE);

    // Request fields seen by the completing access: live inputs when going
    // straight from IDLE to RESP, latched copies otherwise.
    assign w_acc_widx = w_in_idle ? addr[WIDTH-1:2] : r_widx;
    assign w_acc_data = w_in_idle ? wr_data         : r_wdata;
    assign w_acc_wr   = w_in_idle ? mem_wr          : r_is_wr;

    // Access completes on the edge that enters RESP; reset blocks the RAM write.
    assign w_fire = (w_state_next == RESP) & ~rst;

    assign w_in0_hit = (w_acc_widx == IN0_WIDX);
    assign w_in1_hit = (w_acc_widx == IN1_WIDX);
    assign w_out_hit = (w_acc_widx == OUT_WIDX);
    assign w_ram_hit = (64'(w_acc_widx) < DEPTH_LIMIT) & ~w_in0_hit & ~w_in1_hit;
    assign w_ram_we  = w_fire & w_acc_wr & w_ram_hit;

    mem_ram #(
        .WIDTH       (WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_ram_we),
        .i_addr    (w_acc_widx[AW-1:0]),
        .i_wdata   (w_acc_data),
        .o_rdata_c (w_ram_rdata)
    );

    // Read data source select; unmapped reads return zero.
    always_comb begin
        w_rd_mux = '0;
        if (w_in0_hit) begin
            w_rd_mux = WIDTH'(r_inport0);
        end else if (w_in1_hit) begin
            w_rd_mux = WIDTH'(r_inport1);
        end else if (w_ram_hit) begin
            w_rd_mux = w_ram_rdata;
        end
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= 3'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_ready    <= w_ready_next;
            r_busy     <= w_busy_next;
        end
    end

    // Next state, wait counter and next status outputs.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_wait_cnt_next = 3'd0;
                    w_state_next    = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_wait_cnt_next = 3'd0;
                    w_state_next    = RESP;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 3'd1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next    = IDLE;
                w_wait_cnt_next = 3'd0;
            end
        endcase
        w_ready_next = (w_state_next == RESP);
        w_busy_next  = (w_state_next != IDLE);
    end

    // Request latch, read data, outport and inports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_widx    <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            r_rd_data <= '0;
            r_outport <= '0;
            r_inport0 <= '0;
            r_inport1 <= '0;
        end else begin
            if (w_in_idle && w_req) begin
                r_widx  <= addr[WIDTH-1:2];
                r_wdata <= wr_data;
                r_is_wr <= mem_wr;
            end
            if (w_fire && !w_acc_wr) begin
                r_rd_data <= w_rd_mux;
            end
            if (w_fire && w_acc_wr && w_out_hit) begin
                r_outport <= w_acc_data;
            end
            if (inport0_en) begin
                r_inport0 <= switches;
            end
            if (inport1_en) begin
                r_inport1 <= switches;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign ready   = r_ready;
    assign busy    = r_busy;
    assign outport = r_outport;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one instance with one wait state, one with zero.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [9:0]  switches;
    logic        inport0_en;
    logic        inport1_en;

    logic [31:0] rd_data1, outport1;
    logic        ready1, busy1;
    logic [31:0] rd_data0, outport0;
    logic        ready0, busy0;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data1),
        .ready(ready1), .busy(busy1), .switches(switches),
        .inport0_en(inport0_en), .inport1_en(inport1_en), .outport(outport1)
    );

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data0),
        .ready(ready0), .busy(busy0), .switches(switches),
        .inport0_en(inport0_en), .inport1_en(inport1_en), .outport(outport0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? ready0 : ready1;
    endfunction

    function automatic logic bsy(input int inst);
        return (inst == 0) ? busy0 : busy1;
    endfunction

    // Issue one request from IDLE and wait (bounded) for the ready pulse;
    // returns in the ready cycle.
    task automatic access(input int inst, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int lat, input string tag);
        int n;
        mem_rd  = rd;
        mem_wr  = wr;
        addr    = a;
        wr_data = d;
        tick();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        n = 1;
        while (rdy(inst) !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk($sformatf("%s_latency", tag), 32'(n), 32'(lat));
        chk($sformatf("%s_busy", tag), 32'(bsy(inst)), 32'd1);
    endtask

    task automatic to_idle(input int inst, input string tag);
        tick();
        chk($sformatf("%s_ready_drop", tag), 32'(rdy(inst)), 32'd0);
        chk($sformatf("%s_busy_drop", tag), 32'(bsy(inst)), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr       = '0;
        wr_data    = '0;
        switches   = '0;
        inport0_en = 1'b0;
        inport1_en = 1'b0;

        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(ready1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_rd_data", rd_data1, 32'h0);
        chk("rst_outport", outport1, 32'h0);
        chk("rst_ready_ws0", 32'(ready0), 32'd0);
        rst = 1'b0;
        tick();

        // Known contents for later checks.
        access(1, 1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 2, "pre0");
        to_idle(1, "pre0");
        access(1, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 2, "pre20");
        to_idle(1, "pre20");
        access(1, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_0000, 2, "pre30");
        to_idle(1, "pre30");

        // Basic RAM write then read.
        access(1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, "wr10");
        to_idle(1, "wr10");
        access(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, "rd10");
        chk("rd10_data", rd_data1, 32'hDEAD_BEEF);
        to_idle(1, "rd10");

        // Read and write together behave as a write.
        access(1, 1'b1, 1'b1, 32'h0000_0040, 32'h4040_4040, 2, "rdwr40");
        to_idle(1, "rdwr40");
        access(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, "rd40");
        chk("rd40_data", rd_data1, 32'h4040_4040);
        to_idle(1, "rd40");

        // Inports, zero-extended; low address bits ignored.
        switches   = 10'h155;
        inport1_en = 1'b1;
        tick();
        inport1_en = 1'b0;
        access(1, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 2, "in1");
        chk("in1_data", rd_data1, 32'h0000_0155);
        to_idle(1, "in1");
        switches   = 10'h2AA;
        inport0_en = 1'b1;
        tick();
        inport0_en = 1'b0;
        access(1, 1'b1, 1'b0, 32'h0000_FFFB, 32'h0, 2, "in0");
        chk("in0_data", rd_data1, 32'h0000_02AA);
        to_idle(1, "in0");

        // Inport load coinciding with read completion returns the old value.
        switches = 10'h0F0;
        mem_rd   = 1'b1;
        addr     = 32'h0000_FFFC;
        tick();
        mem_rd     = 1'b0;
        inport1_en = 1'b1;
        tick();
        inport1_en = 1'b0;
        chk("race_ready", 32'(ready1), 32'd1);
        chk("race_old", rd_data1, 32'h0000_0155);
        to_idle(1, "race");

        // Outport write visible on the ready cycle; reads of same address hit inport1.
        access(1, 1'b0, 1'b1, 32'h0000_FFFC, 32'h1234_5678, 2, "outwr");
        chk("outwr_value", outport1, 32'h1234_5678);
        to_idle(1, "outwr");
        access(1, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 2, "in1new");
        chk("in1new_data", rd_data1, 32'h0000_00F0);
        to_idle(1, "in1new");

        // Unmapped read returns zero; unmapped write changes nothing.
        access(1, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 2, "unmap_rd");
        chk("unmap_rd_data", rd_data1, 32'h0);
        to_idle(1, "unmap_rd");
        access(1, 1'b0, 1'b1, 32'h0001_0000, 32'hCAFE_F00D, 2, "unmap_wr");
        to_idle(1, "unmap_wr");
        chk("unmap_wr_outport", outport1, 32'h1234_5678);
        access(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 2, "rd0");
        chk("rd0_data", rd_data1, 32'h0BAD_F00D);
        to_idle(1, "rd0");

        // Inputs changed during WAIT must not affect the access.
        mem_wr  = 1'b1;
        addr    = 32'h0000_0030;
        wr_data = 32'h5A5A_5A5A;
        tick();
        mem_wr  = 1'b0;
        addr    = 32'h0000_0034;
        wr_data = 32'hFFFF_FFFF;
        tick();
        chk("latch_ready", 32'(ready1), 32'd1);
        to_idle(1, "latch");
        access(1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 2, "rd30");
        chk("rd30_data", rd_data1, 32'h5A5A_5A5A);
        to_idle(1, "rd30");

        // Read held continuously: back-to-back accesses.
        mem_rd = 1'b1;
        addr   = 32'h0000_0010;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("b2b_ready_ws1_%0d", i), 32'(ready1), 32'((i % 3) == 2));
            chk($sformatf("b2b_ready_ws0_%0d", i), 32'(ready0), 32'((i % 2) == 1));
            if ((i % 3) == 2) begin
                chk($sformatf("b2b_data_%0d", i), rd_data1, 32'hDEAD_BEEF);
            end
        end
        mem_rd = 1'b0;
        tick();
        tick();

        // Reset during WAIT aborts the write.
        mem_wr  = 1'b1;
        addr    = 32'h0000_0020;
        wr_data = 32'hAAAA_5555;
        tick();
        mem_wr = 1'b0;
        chk("abort_busy_before", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_outport", outport1, 32'h0);
        chk("abort_rd_data", rd_data1, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        access(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 2, "rd20");
        chk("rd20_data", rd_data1, 32'h1111_2222);
        chk("rd20_outport", outport1, 32'h0);
        to_idle(1, "rd20");
        access(1, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 2, "in1rst");
        chk("in1rst_data", rd_data1, 32'h0);
        to_idle(1, "in1rst");

        // Zero wait states: ready one cycle after accept.
        access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, "ws0_rd10");
        chk("ws0_rd10_data", rd_data0, 32'hDEAD_BEEF);
        to_idle(0, "ws0_rd10");
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
